// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/response port between the
// instruction fetch unit (read only) and the load/store unit. One
// transaction is in flight at a time; the response is routed back to the
// master that issued it, or flagged as an error if memory never answers.
//
// Handshakes: a request transfers on a cycle where valid and ready are both
// high; valid must stay high, with stable payload, until that cycle.
// Response valids are one-cycle pulses with no back-pressure.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_EN      = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_reqValid,
  output logic                    ifu_reqReady,
  input  logic [ADDR_WIDTH-1:0]   ifu_raddr,
  output logic                    ifu_respValid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_reqValid,
  output logic                    lsu_reqReady,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_respValid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    resp_err,
  output logic                    mem_reqValid,
  input  logic                    mem_reqReady,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_respValid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_owner;
  logic                    r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wen;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wmask;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [7:0]              r_cnt;
  logic                    w_gnt_ifu;
  logic                    w_gnt_lsu;
  logic                    w_timeout;

  assign w_timeout = (r_cnt == 8'(TIMEOUT));

  // Grant decision: only in IDLE and never while reset is held.
  always_comb begin
    w_gnt_ifu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      if (ifu_reqValid && lsu_reqValid) begin
        if ((RR_EN != 0) && (r_last_grant == OWN_LSU)) w_gnt_ifu = 1'b1;
        else                                           w_gnt_lsu = 1'b1;
      end else begin
        w_gnt_ifu = ifu_reqValid;
        w_gnt_lsu = lsu_reqValid;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next        = r_state;
    mem_reqValid  = 1'b0;
    ifu_respValid = 1'b0;
    lsu_respValid = 1'b0;
    resp_err      = 1'b0;
    case (r_state)
      S_IDLE: if (w_gnt_ifu || w_gnt_lsu) w_next = S_REQ;
      S_REQ: begin
        mem_reqValid = 1'b1;
        if (mem_reqReady) w_next = S_WAIT;
      end
      S_WAIT: if (mem_respValid || w_timeout) w_next = S_RESP;
      S_RESP: begin
        ifu_respValid = (r_owner == OWN_IFU);
        lsu_respValid = (r_owner == OWN_LSU);
        resp_err      = r_err;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, response capture and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_LSU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_lsu) begin
            r_owner      <= OWN_LSU;
            r_last_grant <= OWN_LSU;
            r_addr       <= lsu_addr;
            r_wen        <= lsu_wen;
            r_wdata      <= lsu_wdata;
            r_wmask      <= lsu_wmask;
          end else if (w_gnt_ifu) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_addr       <= ifu_raddr;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
          end
        end
        S_REQ: if (mem_reqReady) r_cnt <= '0;
        S_WAIT: begin
          // A response in the same cycle as the timeout still wins.
          if (mem_respValid) begin
            r_rdata <= mem_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ifu_reqReady = w_gnt_ifu;
  assign lsu_reqReady = w_gnt_lsu;
  assign ifu_rdata    = r_rdata;
  assign lsu_rdata    = r_rdata;
  assign mem_addr     = r_addr;
  assign mem_wen      = r_wen;
  assign mem_wdata    = r_wdata;
  assign mem_wmask    = r_wmask;
  assign dbg_state    = r_state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that shares the single memory port between the instruction fetch unit and the load/store unit. It accepts one request at a time from either master, forwards it to memory, waits for the response and routes that response back to the master that issued the request. It sits between the `ifu`/`lsu` request/response handshakes and the `mem` block.

## Interface
- `ADDR_WIDTH`, 32: address width of all ports.
- `DATA_WIDTH`, 32: data width. Mask width is `DATA_WIDTH/8`.
- `RR_EN`, 0: 0 = LSU has fixed priority on ties; 1 = round-robin on ties.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the arbiter aborts with an error. Must be ≥1. 8-bit counter.

Ports:
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Reset. Asynchronous assert, active-high.
- `ifu_reqValid`  in  1  IFU read request valid.
- `ifu_reqReady`  out  1  IFU request accepted this cycle.
- `ifu_raddr`  in  ADDR_WIDTH  IFU read address.
- `ifu_respValid`  out  1  IFU response valid; one-cycle pulse.
- `ifu_rdata`  out  DATA_WIDTH  IFU read data.
- `lsu_reqValid`  in  1  LSU request valid.
- `lsu_reqReady`  out  1  LSU request accepted this cycle.
- `lsu_addr`  in  ADDR_WIDTH  LSU address.
- `lsu_wen`  in  1  LSU write enable.
- `lsu_wdata`  in  DATA_WIDTH  LSU write data.
- `lsu_wmask`  in  DATA_WIDTH/8  LSU byte mask.
- `lsu_respValid`  out  1  LSU response valid; one-cycle pulse.
- `lsu_rdata`  out  DATA_WIDTH  LSU read data.
- `resp_err`  out  1  Qualifies whichever `*_respValid` is high: 1 means the transaction timed out.
- `mem_reqValid`  out  1  Downstream request valid.
- `mem_reqReady`  in  1  Downstream accepts the request.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  widths as for the LSU  Latched downstream request fields.
- `mem_respValid`  in  1  Downstream response valid.
- `mem_rdata`  in  DATA_WIDTH  Downstream read data.

## Operation
- **FSM states:**
  - IDLE: accept one request.
  - REQ: drive `mem_reqValid` until `mem_reqReady`.
  - WAIT: wait for `mem_respValid` or timeout.
  - RESP: one-cycle response to the owner, then back to IDLE.
- **Grant (combinational, IDLE only).**
  - Only one requester valid: that requester is granted.
  - Both valid with `RR_EN`=0: LSU is granted.
  - Both valid with `RR_EN`=1: the master that was not granted last is granted.
  - `*_reqReady` is high only for the granted master, and only in IDLE. It is 0 in every other state.
- **Accept** (`reqValid && reqReady`):
  - Latch address/wen/wdata/wmask and the owner ID.
  - Update `last_grant`.
  - Go to REQ.
  - An IFU grant latches wen=0 and wmask=0.
- **REQ:** `mem_reqValid`=1 with the latched fields, held stable. When `mem_reqReady`=1, go to WAIT and clear the timeout counter.
- **WAIT:**
  - On `mem_respValid`: latch `mem_rdata`, set err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: set rdata=0, err=1, go to RESP.
  - `mem_respValid` is taken in preference to timeout if both happen in the same cycle.
- **RESP:** the owner's `*_respValid`=1 for exactly one cycle, with the latched rdata and `resp_err`. The non-owner's respValid=0. Next state is IDLE.
- `mem_respValid` in IDLE, REQ or RESP is ignored. This covers stale responses after reset or timeout.
- Upstream inputs are ignored outside IDLE. A master must hold `reqValid` until it is accepted.

## Timing
- Reset values:
  - state=IDLE
  - `mem_reqValid`=0
  - both respValid=0
  - `resp_err`=0
  - rdata registers=0
  - `mem_*` fields=0
  - `last_grant`=LSU, so the first RR tie goes to IFU.
- `*_reqReady` is 0 while `rst` is high.
- Minimum latency: accept at cycle 0 → REQ at cycle 1 (ready=1) → WAIT at cycle 2 (respValid=1) → RESP at cycle 3 (master sees respValid) → IDLE at cycle 4, when the next accept is possible. Minimum issue interval is 4 cycles.
- Timeout: RESP is entered `TIMEOUT`+1 cycles after entering WAIT if no response arrives.
- Reset mid-transaction aborts with no response to the owner, and returns to IDLE asynchronously.
- Round-robin pointer updates only on accept, never on a stall.

## Test plan
- IFU only, addr=0x80000000, mem returns 0x00000413 one cycle after accept → `ifu_respValid` pulse at cycle 3 with rdata=0x00000413. `lsu_respValid` stays 0.
- Both request at the same cycle, `RR_EN`=0 → LSU granted first, IFU served next in IDLE. With `RR_EN`=1 over 4 back-to-back ties the grants go IFU, LSU, IFU, LSU.
- LSU write addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, `mem_reqReady` low for 3 cycles → `mem_reqValid` held with fields stable for 4 cycles. A single `lsu_respValid` pulse follows.
- No `mem_respValid` with `TIMEOUT`=4 → owner respValid with `resp_err`=1 and rdata=0, 5 cycles after entering WAIT. A late `mem_respValid` in IDLE is ignored.
- `rst` asserted during WAIT → immediate IDLE, all outputs at reset values, no response pulse. After deassert, a new IFU request completes normally.
